stage_mem1: RTL and testbench
=============================

Name: stage_mem1

Overview:
- Second memory stage, between stage_mem0 (address/request issue) and stage_write.
- Holds one instruction per cycle and waits for the dcache load response, stalling upstream while it waits.
- Aligns and sign/zero-extends load data, converts dcache errors into exceptions and drives the writeback-stage inputs.
- Provides a forwarding/interlock port to decode.

Parameters:
- None. Widths come from the shared package.

Ports:
- clk_core  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- mem0_valid  in  1  mem0 presents a live instruction
- mem0_exc  in  1  instruction already carries an exception
- mem0_exc_cause  in  ecause_t  cause of that exception
- mem0_flush  in  1  instruction requests a pipeline flush at retire
- mem0_pc  in  30  pc[31:2]
- mem0_wb_reg  in  5  destination register; 0 means no write
- mem0_load  in  1  instruction is a load awaiting dcache data
- mem0_store  in  1  instruction is a store; a dcache ack is still required
- mem0_size  in  2  0 = byte, 1 = half, 2 = word
- mem0_unsigned  in  1  zero-extend the load
- mem0_addr_lo  in  2  address bits [1:0]
- mem0_result  in  32  ALU result, or tval/insn word when exc is set
- dc_rvalid  in  1  dcache response valid (one pulse per request)
- dc_rdata  in  32  raw aligned word
- dc_err  in  1  access fault, qualified by dc_rvalid
- wb_stall  in  1  writeback is not accepting this cycle
- csr_kill  in  1  kill all in-flight instructions
- mem1_stall  out  1  mem1 cannot accept from mem0
- mem1_valid_wb  out  1  live, non-excepting instruction for writeback
- mem1_exc  out  1  exception to writeback
- mem1_exc_cause  out  ecause_t
- mem1_flush  out  1
- mem1_pc  out  30
- mem1_wb_reg  out  5
- mem1_dout  out  32  formatted load data, or mem0_result
- mem1_fwd_valid  out  1  mem1_fwd_data is usable for bypass
- mem1_fwd_busy  out  1  mem1_wb_reg has a pending result; decode must interlock
- mem1_fwd_reg  out  5

Behaviour:
- Instruction register (ins_*):
  - Captured from mem0_* when ~mem1_stall.
  - ins_valid <= mem0_valid & ~csr_kill.
- Reset: ins_valid=0, ins_exc=0, state=RUN, ld_have=0, so every valid/exc/stall output is 0. Other data registers are don't-care.
- need_dc = ins_valid & ~ins_exc & (ins_load | ins_store).
- dc_ok = dc_rvalid & ~dc_err.
- State machine:
  - RUN → DRAIN when csr_kill & need_dc & ~ld_have & ~dc_rvalid; otherwise remain in RUN.
  - DRAIN: the next dc_rvalid is discarded, then → RUN. mem1_stall=1 throughout.
  - Reset in any state → RUN.
- ld_have/ld_buf:
  - Set and latched when dc_rvalid arrives in RUN while wb_stall holds the instruction.
  - Cleared when the instruction advances or on csr_kill.
- got = ld_have | dc_rvalid; data source = ld_have ? ld_buf : dc_rdata.
- mem1_stall = (state==DRAIN) | wb_stall | (need_dc & ~got).
- Outputs in RUN:
  - mem1_valid_wb = ins_valid & ~ins_exc & ~dc_fault & (~need_dc | got).
  - dc_fault = need_dc & got & err. The err bit is also latched into ld_buf.
  - mem1_exc = ins_valid & (ins_exc | dc_fault).
  - mem1_exc_cause = ins_exc ? ins_exc_cause : (ins_store ? SACCESS : LACCESS).
  - mem1_flush, mem1_pc, mem1_wb_reg pass straight from ins_*.
- Load formatting:
  - Shift the data source right by 8*addr_lo.
  - Byte: bits [7:0], extended from bit 7. Half: bits [15:0], extended from bit 15. Word: unchanged.
  - Unsigned loads zero-extend; signed loads sign-extend.
  - Misaligned accesses never reach this stage; mem0 has already raised the exception.
- mem1_dout = formatted load when ins_load & ~ins_exc & ~dc_fault; otherwise ins_result.
- Bubbles: when waiting, all outputs to writeback deassert. A stall never creates a duplicate or lost instruction.
- csr_kill:
  - Same-cycle: ins_valid <= 0; outputs for that cycle are still driven.
  - Takes priority over the wb_stall hold.
- Forwarding:
  - mem1_fwd_reg = ins_wb_reg.
  - mem1_fwd_busy = ins_valid & ~ins_exc & (ins_wb_reg != 0).
  - mem1_fwd_valid = mem1_fwd_busy & (~ins_load | got).
  - mem1_fwd_data is not a separate port; it equals mem1_dout.
- A dc_rvalid when no dcache access is pending and state!=DRAIN is a protocol error. Raise a simulation-only assertion.

Decomposition:
- defines.svh: ecause_t, extended with LACCESS and SACCESS (add if absent); size encodings MEM_B/MEM_H/MEM_W.
- One sub-module, load_align: combinational format of data/addr_lo/size/unsigned → 32b.

Test Plan:
- Word load, addr 0x100, dc_rvalid in the same cycle with 0xDEADBEEF → mem1_valid_wb=1, mem1_dout=0xDEADBEEF, mem1_stall=0.
- Signed byte load, addr_lo=3, rdata 0x80112233, response after 3 cycles → mem1_stall=1 for 3 cycles with valid_wb=0, then mem1_dout=0xFFFFFF80. Unsigned half, addr_lo=2 → 0x00008011.
- Load response arrives while wb_stall=1 for 2 cycles → data held in ld_buf, mem1_dout stable, exactly one mem1_valid_wb accept after wb_stall drops.
- dc_err on a load at pc 0x200 → mem1_exc=1, cause LACCESS, valid_wb=0, mem1_pc=0x80.
- csr_kill while a load is waiting → next cycle state DRAIN, stall=1; the late dc_rvalid (0x12345678) is discarded, no retire occurs, then back to RUN.
- Reset asserted mid-DRAIN → all outputs 0, state RUN; the following load completes normally.

Source files
------------

// File: rtl/stage_mem1_pkg.sv
// Shared types and constants for the mem1 pipeline stage: exception causes,
// access size encodings, FSM states and the captured instruction record.
package stage_mem1_pkg;

    localparam int XLEN  = 32;
    localparam int PC_W  = 30;
    localparam int REG_W = 5;

    // Exception causes, numbered like the RISC-V mcause exception codes.
    typedef enum logic [3:0] {
        IMISALIGN = 4'd0,
        IACCESS   = 4'd1,
        ILLEGAL   = 4'd2,
        BREAK     = 4'd3,
        LMISALIGN = 4'd4,
        LACCESS   = 4'd5,
        SMISALIGN = 4'd6,
        SACCESS   = 4'd7,
        ECALL_U   = 4'd8,
        ECALL_M   = 4'd11
    } ecause_t;

    // Load/store access size.
    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // RUN: normal operation. DRAIN: swallow the response of a killed load.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } mem1_state_t;

    // Payload of the instruction held in mem1 (valid/exc kept separately).
    typedef struct packed {
        ecause_t           exc_cause;
        logic              flush;
        logic [PC_W-1:0]   pc;
        logic [REG_W-1:0]  wb_reg;
        logic              load;
        logic              store;
        logic [1:0]        size;
        logic              is_unsigned;
        logic [1:0]        addr_lo;
        logic [XLEN-1:0]   result;
    } mem1_ins_t;

endpackage

// File: rtl/stage_mem1_load_align.sv
// Load data formatter: shifts the dcache word down to the addressed byte lane,
// then keeps byte/half/word and sign- or zero-extends it to 32 bits.
module stage_mem1_load_align
    import stage_mem1_pkg::*;
(
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_addr_lo,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_shifted;
    logic            w_sign_b;
    logic            w_sign_h;

    assign w_shifted = i_data >> {i_addr_lo, 3'b000};
    assign w_sign_b  = w_shifted[7]  & ~i_unsigned;
    assign w_sign_h  = w_shifted[15] & ~i_unsigned;

    // Select the access width and extend from its top bit.
    always_comb begin
        // NOTE: o_data gets a value before the case so every path assigns it; no latch is inferred.
        o_data = w_shifted;
        case (i_size)
            MEM_B:   o_data = {{24{w_sign_b}}, w_shifted[7:0]};
            MEM_H:   o_data = {{16{w_sign_h}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/stage_mem1.sv
// Second memory stage: holds one instruction, waits for its dcache response,
// formats load data, turns dcache errors into exceptions and feeds writeback.
// A kill while a load is outstanding drains the orphaned response.
module stage_mem1
    import stage_mem1_pkg::*;
(
    input  logic             clk_core,
    input  logic             reset_n,
    input  logic             mem0_valid,
    input  logic             mem0_exc,
    input  ecause_t          mem0_exc_cause,
    input  logic             mem0_flush,
    input  logic [PC_W-1:0]  mem0_pc,
    input  logic [REG_W-1:0] mem0_wb_reg,
    input  logic             mem0_load,
    input  logic             mem0_store,
    input  logic [1:0]       mem0_size,
    input  logic             mem0_unsigned,
    input  logic [1:0]       mem0_addr_lo,
    input  logic [XLEN-1:0]  mem0_result,
    input  logic             dc_rvalid,
    input  logic [XLEN-1:0]  dc_rdata,
    input  logic             dc_err,
    input  logic             wb_stall,
    input  logic             csr_kill,
    output logic             mem1_stall,
    output logic             mem1_valid_wb,
    output logic             mem1_exc,
    output ecause_t          mem1_exc_cause,
    output logic             mem1_flush,
    output logic [PC_W-1:0]  mem1_pc,
    output logic [REG_W-1:0] mem1_wb_reg,
    output logic [XLEN-1:0]  mem1_dout,
    output logic             mem1_fwd_valid,
    output logic             mem1_fwd_busy,
    output logic [REG_W-1:0] mem1_fwd_reg
);

    mem1_state_t     r_state;
    mem1_state_t     w_state_next;
    logic            r_ins_valid;
    logic            r_ins_exc;
    mem1_ins_t       r_ins;
    logic            r_ld_have;
    logic [XLEN-1:0] r_ld_buf_data;
    logic            r_ld_buf_err;

    logic            w_need_dc;
    logic            w_got;
    logic [XLEN-1:0] w_src;
    logic            w_err;
    logic            w_dc_fault;
    logic            w_advance;
    logic            w_ld_capture;
    logic [XLEN-1:0] w_load_fmt;

    // A response is owed for any live, non-excepting load or store.
    assign w_need_dc  = r_ins_valid & ~r_ins_exc & (r_ins.load | r_ins.store);
    assign w_got      = r_ld_have | dc_rvalid;
    assign w_src      = r_ld_have ? r_ld_buf_data : dc_rdata;
    assign w_err      = r_ld_have ? r_ld_buf_err  : dc_err;
    assign w_dc_fault = w_need_dc & w_got & w_err;
    assign w_advance  = ~mem1_stall;

    // Park the response when writeback holds the instruction in the arrival cycle.
    assign w_ld_capture = (r_state == ST_RUN) & dc_rvalid & w_need_dc & ~r_ld_have
                        & wb_stall & ~csr_kill;

    // Control half of the instruction register; a kill overrides any hold.
    always_ff @(posedge clk_core) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            r_ins_valid <= 1'b0;
            r_ins_exc   <= 1'b0;
        end else begin
            if (w_advance) begin
                r_ins_exc <= mem0_exc;
            end
            if (csr_kill) begin
                r_ins_valid <= 1'b0;
            end else if (w_advance) begin
                r_ins_valid <= mem0_valid;
            end
        end
    end

    // Payload half of the instruction register, loaded whenever mem1 accepts.
    always_ff @(posedge clk_core) begin
        // NOTE: payload flops are deliberately unreset; they are only observed while r_ins_valid is set.
        if (w_advance) begin
            r_ins <= '{exc_cause:   mem0_exc_cause,
                       flush:       mem0_flush,
                       pc:          mem0_pc,
                       wb_reg:      mem0_wb_reg,
                       load:        mem0_load,
                       store:       mem0_store,
                       size:        mem0_size,
                       is_unsigned: mem0_unsigned,
                       addr_lo:     mem0_addr_lo,
                       result:      mem0_result};
        end
    end

    // Buffered-response flag: set on a held arrival, cleared on advance or kill.
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            r_ld_have <= 1'b0;
        end else if (csr_kill || w_advance) begin
            r_ld_have <= 1'b0;
        end else if (w_ld_capture) begin
            r_ld_have <= 1'b1;
        end
    end

    // Buffered response data and error bit.
    always_ff @(posedge clk_core) begin
        if (w_ld_capture) begin
            r_ld_buf_data <= dc_rdata;
            r_ld_buf_err  <= dc_err;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state plus the stall and writeback handshake outputs.
    always_comb begin
        w_state_next  = r_state;
        mem1_stall    = wb_stall | (w_need_dc & ~w_got);
        mem1_valid_wb = r_ins_valid & ~r_ins_exc & ~w_dc_fault & (~w_need_dc | w_got);
        mem1_exc      = r_ins_valid & (r_ins_exc | w_dc_fault);
        case (r_state)
            ST_RUN: begin
                if (csr_kill && w_need_dc && !r_ld_have && !dc_rvalid) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                mem1_stall    = 1'b1;
                mem1_valid_wb = 1'b0;
                mem1_exc      = 1'b0;
                if (dc_rvalid) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    stage_mem1_load_align u_load_align (
        .i_data     (w_src),
        .i_addr_lo  (r_ins.addr_lo),
        .i_size     (r_ins.size),
        .i_unsigned (r_ins.is_unsigned),
        .o_data     (w_load_fmt)
    );

    assign mem1_exc_cause = r_ins_exc   ? r_ins.exc_cause
                          : r_ins.store ? SACCESS : LACCESS;
    assign mem1_flush     = r_ins.flush;
    assign mem1_pc        = r_ins.pc;
    assign mem1_wb_reg    = r_ins.wb_reg;
    assign mem1_dout      = (r_ins.load & ~r_ins_exc & ~w_dc_fault) ? w_load_fmt : r_ins.result;

    // Decode bypass: busy while a result is owed, valid once the data exists.
    assign mem1_fwd_reg   = r_ins.wb_reg;
    assign mem1_fwd_busy  = r_ins_valid & ~r_ins_exc & (r_ins.wb_reg != '0);
    assign mem1_fwd_valid = mem1_fwd_busy & (~r_ins.load | w_got);

    // Responses may only arrive for an outstanding access or while draining.
    assert property (@(posedge clk_core) disable iff (!reset_n)
        dc_rvalid |-> ((r_state == ST_DRAIN) || (w_need_dc && !r_ld_have)))
        else $error("stage_mem1: dc_rvalid with no outstanding dcache access");

endmodule

// File: tb/tb_stage_mem1.sv
// Bench for stage_mem1: directed scenarios plus randomized transactions
// checked against an arithmetic reference model of the stage behaviour.
module tb_stage_mem1;
    import stage_mem1_pkg::*;

    logic        clk_core = 1'b0;
    logic        reset_n;
    logic        mem0_valid, mem0_exc, mem0_flush, mem0_load, mem0_store, mem0_unsigned;
    ecause_t     mem0_exc_cause;
    logic [29:0] mem0_pc;
    logic [4:0]  mem0_wb_reg;
    logic [1:0]  mem0_size, mem0_addr_lo;
    logic [31:0] mem0_result;
    logic        dc_rvalid, dc_err, wb_stall, csr_kill;
    logic [31:0] dc_rdata;
    logic        mem1_stall, mem1_valid_wb, mem1_exc, mem1_flush;
    ecause_t     mem1_exc_cause;
    logic [29:0] mem1_pc;
    logic [4:0]  mem1_wb_reg, mem1_fwd_reg;
    logic [31:0] mem1_dout;
    logic        mem1_fwd_valid, mem1_fwd_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_core = ~clk_core;

    stage_mem1 dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .mem0_valid(mem0_valid), .mem0_exc(mem0_exc), .mem0_exc_cause(mem0_exc_cause),
        .mem0_flush(mem0_flush), .mem0_pc(mem0_pc), .mem0_wb_reg(mem0_wb_reg),
        .mem0_load(mem0_load), .mem0_store(mem0_store), .mem0_size(mem0_size),
        .mem0_unsigned(mem0_unsigned), .mem0_addr_lo(mem0_addr_lo), .mem0_result(mem0_result),
        .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_err(dc_err),
        .wb_stall(wb_stall), .csr_kill(csr_kill),
        .mem1_stall(mem1_stall), .mem1_valid_wb(mem1_valid_wb), .mem1_exc(mem1_exc),
        .mem1_exc_cause(mem1_exc_cause), .mem1_flush(mem1_flush), .mem1_pc(mem1_pc),
        .mem1_wb_reg(mem1_wb_reg), .mem1_dout(mem1_dout),
        .mem1_fwd_valid(mem1_fwd_valid), .mem1_fwd_busy(mem1_fwd_busy), .mem1_fwd_reg(mem1_fwd_reg)
    );

    // Reference load formatter: pick the addressed bytes numerically and extend.
    function automatic logic [31:0] model_load(input logic [31:0] w, input int sz, input bit uns, input int off);
        longint v;
        int     nbits;
        nbits = (sz == 0) ? 8 : (sz == 1) ? 16 : 32;
        v = {32'd0, w};
        v = v / (longint'(1) << (8 * off));
        v = v % (longint'(1) << nbits);
        if (!uns && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
        return v[31:0];
    endfunction

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic next_cycle();
        @(posedge clk_core);
        #1;
        mem0_valid = 1'b0;
        dc_rvalid  = 1'b0;
        dc_err     = 1'b0;
        wb_stall   = 1'b0;
        csr_kill   = 1'b0;
    endtask

    task automatic drive_mem0(input bit ld, input bit st, input bit exc, input ecause_t cause,
                              input bit fl, input logic [29:0] pc, input logic [4:0] rd,
                              input logic [1:0] sz, input bit uns, input logic [1:0] lo,
                              input logic [31:0] res);
        mem0_valid = 1'b1; mem0_load = ld; mem0_store = st; mem0_exc = exc;
        mem0_exc_cause = cause; mem0_flush = fl; mem0_pc = pc; mem0_wb_reg = rd;
        mem0_size = sz; mem0_unsigned = uns; mem0_addr_lo = lo; mem0_result = res;
    endtask

    // Present one instruction for a cycle; it is live in mem1 from the next cycle.
    task automatic issue(input bit ld, input bit st, input bit exc, input ecause_t cause,
                         input logic [29:0] pc, input logic [4:0] rd, input logic [1:0] sz,
                         input bit uns, input logic [1:0] lo, input logic [31:0] res);
        next_cycle();
        drive_mem0(ld, st, exc, cause, 1'b0, pc, rd, sz, uns, lo, res);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_mem0(1'b1, 1'b0, 1'b1, ILLEGAL, 1'b1, 30'h3, 5'd3, MEM_W, 1'b0, 2'd0, 32'h1);
        dc_rvalid = 1'b0; dc_err = 1'b0; dc_rdata = '0; wb_stall = 1'b0; csr_kill = 1'b0;
        repeat (2) @(posedge clk_core);
        @(negedge clk_core);
        n_tests++; if ({mem1_stall, mem1_valid_wb, mem1_exc, mem1_fwd_busy, mem1_fwd_valid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 00000", {mem1_stall, mem1_valid_wb, mem1_exc, mem1_fwd_busy, mem1_fwd_valid}); end
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk_core);
        n_tests++; if ({mem1_stall, mem1_valid_wb, mem1_exc} !== 3'b0) begin
            n_fail++; $display("FAIL reset_release: got %b want 000", {mem1_stall, mem1_valid_wb, mem1_exc}); end
    endtask

    task automatic test_word_load();
        issue(1'b1, 1'b0, 1'b0, ILLEGAL, 30'h40, 5'd5, MEM_W, 1'b0, 2'd0, 32'h100);
        next_cycle();
        dc_rvalid = 1'b1; dc_rdata = 32'hDEADBEEF;
        @(negedge clk_core);
        n_tests++; if ({mem1_valid_wb, mem1_stall, mem1_fwd_valid} !== 3'b101) begin
            n_fail++; $display("FAIL word_handshake: got %b want 101", {mem1_valid_wb, mem1_stall, mem1_fwd_valid}); end
        n_tests++; if (mem1_dout !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL word_dout: got %h want deadbeef", mem1_dout); end
        n_tests++; if (mem1_fwd_reg !== 5'd5) begin
            n_fail++; $display("FAIL word_fwd_reg: got %0d want 5", mem1_fwd_reg); end
        next_cycle();
        @(negedge clk_core);
        n_tests++; if (mem1_valid_wb !== 1'b0) begin
            n_fail++; $display("FAIL word_no_duplicate: got %b want 0", mem1_valid_wb); end
    endtask

    task automatic test_byte_half();
        logic [31:0] exp;
        issue(1'b1, 1'b0, 1'b0, ILLEGAL, 30'h41, 5'd7, MEM_B, 1'b0, 2'd3, 32'h107);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            dc_rdata = $urandom;
            @(negedge clk_core);
            n_tests++; if ({mem1_stall, mem1_valid_wb, mem1_fwd_busy, mem1_fwd_valid} !== 4'b1010) begin
                n_fail++; $display("FAIL byte_wait%0d: got %b want 1010", i, {mem1_stall, mem1_valid_wb, mem1_fwd_busy, mem1_fwd_valid}); end
        end
        next_cycle();
        dc_rvalid = 1'b1; dc_rdata = 32'h80112233;
        exp = model_load(32'h80112233, 0, 1'b0, 3);
        @(negedge clk_core);
        n_tests++; if (mem1_dout !== exp || mem1_valid_wb !== 1'b1 || mem1_stall !== 1'b0) begin
            n_fail++; $display("FAIL byte_signed: got dout=%h valid=%b stall=%b want dout=%h valid=1 stall=0", mem1_dout, mem1_valid_wb, mem1_stall, exp); end
        issue(1'b1, 1'b0, 1'b0, ILLEGAL, 30'h42, 5'd8, MEM_H, 1'b1, 2'd2, 32'h10A);
        next_cycle();
        dc_rvalid = 1'b1; dc_rdata = 32'h80112233;
        exp = model_load(32'h80112233, 1, 1'b1, 2);
        @(negedge clk_core);
        n_tests++; if (mem1_dout !== exp || mem1_valid_wb !== 1'b1) begin
            n_fail++; $display("FAIL half_unsigned: got dout=%h valid=%b want dout=%h valid=1", mem1_dout, mem1_valid_wb, exp); end
    endtask

    task automatic test_wb_hold();
        logic [31:0] exp;
        int          accepts;
        accepts = 0;
        exp = model_load(32'h1234F00D, 1, 1'b0, 0);
        issue(1'b1, 1'b0, 1'b0, ILLEGAL, 30'h50, 5'd9, MEM_H, 1'b0, 2'd0, 32'h140);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            if (c == 0) begin dc_rvalid = 1'b1; dc_rdata = 32'h1234F00D; end
            else dc_rdata = $urandom;
            wb_stall = (c < 2);
            @(negedge clk_core);
            if (mem1_valid_wb && !wb_stall) accepts++;
            if (c < 3) begin
                n_tests++; if (mem1_dout !== exp || mem1_stall !== wb_stall || mem1_valid_wb !== 1'b1) begin
                    n_fail++; $display("FAIL hold_c%0d: got dout=%h stall=%b valid=%b want dout=%h stall=%b valid=1", c, mem1_dout, mem1_stall, mem1_valid_wb, exp, wb_stall); end
            end
        end
        n_tests++; if (accepts !== 1) begin
            n_fail++; $display("FAIL hold_accepts: got %0d want 1", accepts); end
    endtask

    task automatic test_dc_err();
        issue(1'b1, 1'b0, 1'b0, ILLEGAL, 30'h80, 5'd3, MEM_W, 1'b0, 2'd0, 32'h200);
        next_cycle();
        dc_rvalid = 1'b1; dc_err = 1'b1; dc_rdata = $urandom;
        @(negedge clk_core);
        n_tests++; if ({mem1_exc, mem1_valid_wb, mem1_stall} !== 3'b100 || mem1_exc_cause !== LACCESS) begin
            n_fail++; $display("FAIL load_err: got exc=%b valid=%b stall=%b cause=%0d want 1/0/0 cause=%0d", mem1_exc, mem1_valid_wb, mem1_stall, mem1_exc_cause, LACCESS); end
        n_tests++; if (mem1_pc !== 30'h80 || mem1_dout !== 32'h200) begin
            n_fail++; $display("FAIL load_err_pc: got pc=%h dout=%h want pc=80 dout=200", mem1_pc, mem1_dout); end
        issue(1'b0, 1'b1, 1'b0, ILLEGAL, 30'h81, 5'd0, MEM_W, 1'b0, 2'd0, 32'hCAFE);
        next_cycle();
        dc_rvalid = 1'b1; dc_err = 1'b1;
        @(negedge clk_core);
        n_tests++; if (mem1_exc !== 1'b1 || mem1_exc_cause !== SACCESS || mem1_valid_wb !== 1'b0) begin
            n_fail++; $display("FAIL store_err: got exc=%b cause=%0d valid=%b want exc=1 cause=%0d valid=0", mem1_exc, mem1_exc_cause, mem1_valid_wb, SACCESS); end
    endtask

    task automatic test_passthrough();
        issue(1'b1, 1'b0, 1'b1, LMISALIGN, 30'h90, 5'd12, MEM_W, 1'b0, 2'd1, 32'h241);
        next_cycle();
        @(negedge clk_core);
        n_tests++; if ({mem1_exc, mem1_valid_wb, mem1_stall, mem1_fwd_busy} !== 4'b1000 || mem1_exc_cause !== LMISALIGN) begin
            n_fail++; $display("FAIL pre_exc: got exc/valid/stall/busy=%b cause=%0d want 1000 cause=%0d", {mem1_exc, mem1_valid_wb, mem1_stall, mem1_fwd_busy}, mem1_exc_cause, LMISALIGN); end
        n_tests++; if (mem1_dout !== 32'h241) begin
            n_fail++; $display("FAIL pre_exc_dout: got %h want 241", mem1_dout); end
    endtask

    task automatic test_kill_drain();
        int retires;
        retires = 0;
        issue(1'b1, 1'b0, 1'b0, ILLEGAL, 30'h60, 5'd4, MEM_W, 1'b0, 2'd0, 32'h180);
        next_cycle();
        @(negedge clk_core);
        next_cycle();
        csr_kill = 1'b1;
        @(negedge clk_core);
        n_tests++; if ({mem1_stall, mem1_valid_wb, mem1_fwd_busy} !== 3'b101) begin
            n_fail++; $display("FAIL kill_cycle: got stall/valid/busy=%b want 101", {mem1_stall, mem1_valid_wb, mem1_fwd_busy}); end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive_mem0(1'b0, 1'b0, 1'b0, ILLEGAL, 1'b0, 30'h99, 5'd6, MEM_W, 1'b0, 2'd0, 32'h5555);
            if (c == 1) begin dc_rvalid = 1'b1; dc_rdata = 32'h12345678; end
            @(negedge clk_core);
            if (mem1_valid_wb) retires++;
            n_tests++; if (mem1_stall !== (c < 2) || mem1_exc !== 1'b0) begin
                n_fail++; $display("FAIL drain_c%0d: got stall=%b exc=%b want stall=%b exc=0", c, mem1_stall, mem1_exc, (c < 2)); end
        end
        n_tests++; if (retires !== 0) begin
            n_fail++; $display("FAIL drain_retire: got %0d retires want 0", retires); end
        next_cycle();
        @(negedge clk_core);
        n_tests++; if (mem1_valid_wb !== 1'b1 || mem1_dout !== 32'h5555 || mem1_pc !== 30'h99) begin
            n_fail++; $display("FAIL drain_held_insn: got valid=%b dout=%h pc=%h want 1/5555/99", mem1_valid_wb, mem1_dout, mem1_pc); end
    endtask

    task automatic test_reset_drain();
        logic [31:0] data;
        issue(1'b1, 1'b0, 1'b0, ILLEGAL, 30'h70, 5'd10, MEM_W, 1'b0, 2'd0, 32'h1C0);
        next_cycle();
        csr_kill = 1'b1;
        next_cycle();
        @(negedge clk_core);
        n_tests++; if (mem1_stall !== 1'b1) begin
            n_fail++; $display("FAIL rst_drain_entry: got stall=%b want 1", mem1_stall); end
        next_cycle();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b0;
        @(negedge clk_core);
        n_tests++; if ({mem1_stall, mem1_valid_wb, mem1_exc, mem1_fwd_busy, mem1_fwd_valid} !== 5'b0) begin
            n_fail++; $display("FAIL rst_drain_outputs: got %b want 00000", {mem1_stall, mem1_valid_wb, mem1_exc, mem1_fwd_busy, mem1_fwd_valid}); end
        next_cycle();
        reset_n = 1'b1;
        data = $urandom;
        issue(1'b1, 1'b0, 1'b0, ILLEGAL, 30'h71, 5'd11, MEM_W, 1'b0, 2'd0, 32'h1C4);
        next_cycle();
        dc_rvalid = 1'b1; dc_rdata = data;
        @(negedge clk_core);
        n_tests++; if (mem1_valid_wb !== 1'b1 || mem1_dout !== data || mem1_stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_drain_next_load: got valid=%b dout=%h stall=%b want 1/%h/0", mem1_valid_wb, mem1_dout, mem1_stall, data); end
    endtask

    task automatic test_random();
        ecause_t     causes [4] = '{ILLEGAL, LMISALIGN, SMISALIGN, BREAK};
        int          kind, delay, hold, accepts;
        bit          ld, st, exc, fl, uns, err, need, fault, exp_exc, exp_busy;
        ecause_t     cause, exp_cause;
        logic [1:0]  sz, lo;
        logic [4:0]  rd;
        logic [29:0] pc;
        logic [31:0] res, rdata, exp_dout;
        logic [3:0]  exp4;
        for (int t = 0; t < 60; t++) begin
            kind  = $urandom_range(0, 3);
            exc   = (kind == 3);
            ld    = (kind == 1) || (exc && $urandom_range(0, 1) == 1);
            st    = (kind == 2);
            cause = causes[$urandom_range(0, 3)];
            fl    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            sz    = 2'($urandom_range(0, 2));
            lo    = (sz == MEM_W) ? 2'd0 : (sz == MEM_H) ? {1'($urandom_range(0, 1)), 1'b0} : 2'($urandom_range(0, 3));
            rd    = st ? 5'd0 : 5'($urandom_range(0, 31));
            pc    = 30'($urandom);
            res   = $urandom;
            rdata = $urandom;
            err   = ($urandom_range(0, 7) == 0);
            delay = $urandom_range(0, 3);
            hold  = $urandom_range(0, 2);
            need      = !exc && (ld || st);
            fault     = need && err;
            exp_exc   = exc || fault;
            exp_cause = exc ? cause : (st ? SACCESS : LACCESS);
            exp_dout  = (ld && !exc && !fault) ? model_load(rdata, int'(sz), uns, int'(lo)) : res;
            exp_busy  = !exc && (rd != 5'd0);
            accepts   = 0;
            issue(ld, st, exc, cause, pc, rd, sz, uns, lo, res);
            mem0_flush = fl;
            if (need) begin
                for (int d = 0; d < delay; d++) begin
                    next_cycle();
                    dc_rdata = $urandom;
                    @(negedge clk_core);
                    exp4 = {1'b1, 1'b0, 1'b0, exp_busy && !ld};
                    n_tests++; if ({mem1_stall, mem1_valid_wb, mem1_exc, mem1_fwd_valid} !== exp4 || mem1_fwd_busy !== exp_busy) begin
                        n_fail++; $display("FAIL rnd%0d_wait%0d: got stall/valid/exc/fwdv=%b busy=%b want %b busy=%b", t, d, {mem1_stall, mem1_valid_wb, mem1_exc, mem1_fwd_valid}, mem1_fwd_busy, exp4, exp_busy); end
                end
            end
            for (int c = 0; c <= hold; c++) begin
                next_cycle();
                if (c == 0 && need) begin dc_rvalid = 1'b1; dc_rdata = rdata; dc_err = err; end
                else dc_rdata = $urandom;
                wb_stall = (c < hold);
                @(negedge clk_core);
                if (mem1_valid_wb && !wb_stall) accepts++;
                n_tests++; if (mem1_valid_wb !== !exp_exc || mem1_exc !== exp_exc || mem1_stall !== wb_stall
                               || (exp_exc && mem1_exc_cause !== exp_cause)) begin
                    n_fail++; $display("FAIL rnd%0d_ctl%0d: got valid=%b exc=%b stall=%b cause=%0d want valid=%b exc=%b stall=%b cause=%0d", t, c, mem1_valid_wb, mem1_exc, mem1_stall, mem1_exc_cause, !exp_exc, exp_exc, wb_stall, exp_cause); end
                n_tests++; if (mem1_dout !== exp_dout || mem1_pc !== pc || mem1_wb_reg !== rd || mem1_flush !== fl) begin
                    n_fail++; $display("FAIL rnd%0d_data%0d: got dout=%h pc=%h rd=%0d fl=%b want dout=%h pc=%h rd=%0d fl=%b", t, c, mem1_dout, mem1_pc, mem1_wb_reg, mem1_flush, exp_dout, pc, rd, fl); end
                n_tests++; if (mem1_fwd_busy !== exp_busy || mem1_fwd_valid !== exp_busy || mem1_fwd_reg !== rd) begin
                    n_fail++; $display("FAIL rnd%0d_fwd%0d: got busy=%b valid=%b reg=%0d want busy=%b valid=%b reg=%0d", t, c, mem1_fwd_busy, mem1_fwd_valid, mem1_fwd_reg, exp_busy, exp_busy, rd); end
            end
            n_tests++; if (accepts !== (exp_exc ? 0 : 1)) begin
                n_fail++; $display("FAIL rnd%0d_accepts: got %0d want %0d", t, accepts, (exp_exc ? 0 : 1)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_half();
        test_wb_hold();
        test_dc_err();
        test_passthrough();
        test_kill_drain();
        test_reset_drain();
        test_random();
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
